rv_decode_stage: RTL
====================

Name: rv_decode_stage

Overview:
Parametrised ID stage for the RV pipeline. It takes over the role of the current decode block and covers the full RV32I/RV64I base opcode set. Contains the integer register file with write-back bypass, generates all immediate formats, and detects load-use hazards against the instruction it is currently holding. Sits between fetch and execute, with a valid/ready handshake on both sides.

Parameters:
XLEN, 64, datapath width; 32 or 64 only.
NREG, 32, architectural register count; 32 (I) or 16 (E).

Ports:
CLK  in  1  clock, all state on posedge.
reset  in  1  asynchronous, active-low.
in_valid  in  1  fetch presents inst/pc.
in_ready  out  1  decode accepts inst this cycle.
inst  in  32  instruction word.
pc  in  XLEN  address of inst.
flush  in  1  kill held and incoming instruction (branch redirect).
wb_en  in  1  register write enable.
wb_rd  in  5  write index.
wb_value  in  XLEN  write data.
ex_ready  in  1  execute accepts the output bundle.
out_valid  out  1  output bundle valid.
rd, rs1, rs2  out  5 each  decoded register indices.
funct3  out  3; funct7  out  7.
op1, op2  out  XLEN  ALU operands.
store_data  out  XLEN  rs2 value for stores.
imm  out  XLEN  sign-extended immediate.
pc_out  out  XLEN  pc of the held instruction.
write_back, mem_acc, load_flag, store_flag, branch_flag, jump_flag, imm_flag, word_flag, illegal  out  1 each  class flags.
stall_raise  out  1  load-use bubble inserted this cycle.

Behaviour:
- Reset: register file all zero; every output zero; in_ready = 1.
- Register file: NREG x XLEN. Written at posedge when wb_en and wb_rd != 0. x0 always reads 0. A read with index == wb_rd and wb_en high returns wb_value in the same cycle (bypass).
- Output register advances when (!out_valid || ex_ready). Latency is 1 cycle from acceptance to out_valid.
- in_ready = advance && !hazard && !flush. Exception: during flush, in_ready = 1 and the input is discarded.
- hazard: all of the following hold:
  - out_valid && load_flag && rd != 0;
  - the incoming instruction uses rs1 and rs1 == rd, or uses rs2 and rs2 == rd.
  - rs1 users: all classes except LUI, AUIPC, JAL. rs2 users: R-type, BRANCH, STORE.
- On hazard with advance: out_valid <= 0 for exactly one cycle (bubble) and stall_raise <= 1. Forwarding downstream resolves the rest. stall_raise is 0 in every other cycle.
- flush: out_valid <= 0 at the next edge and takes priority over hazard and advance. Register-file writes still occur.
- When ex_ready is low and out_valid is high, every output holds stable.
- Decode, by opcode class:
  - R-type (0110011): op1 = rs1 value, op2 = rs2 value.
  - OP-IMM (0010011): op2 = I-immediate.
  - LOAD: op1 = rs1 value, op2 = I-immediate, funct3 carries the width.
  - STORE: op1 = rs1 value, op2 = S-immediate, store_data = rs2 value, write_back = 0.
  - BRANCH: op1/op2 = rs1/rs2 values, imm = B-immediate, write_back = 0.
  - LUI: op1 = 0, op2 = U-immediate.
  - AUIPC: op1 = pc, op2 = U-immediate.
  - JAL: op1 = pc, op2 = 4, imm = J-immediate.
  - JALR: op1 = pc, op2 = 4, imm = I-immediate, rs1 value sent on store_data.
  - XLEN = 64 only: OP-32 and OP-IMM-32 also set word_flag.
- Immediates are sign-extended from bit 31 to XLEN.
- illegal = 1 (with write_back = 0, mem_acc = 0) for:
  - an unknown opcode;
  - OP-32 or OP-IMM-32 when XLEN = 32;
  - any used register index >= NREG.
- An illegal instruction still issues with out_valid = 1.

Decomposition:
- Shared package rv_decode_pkg: opcode constants (including OP-32, LUI, AUIPC, JAL, JALR, STORE), an immediate-format enum (I/S/B/U/J), and the NOP encoding 32'h00000013.
- One sub-module, rv_regfile: parametrised on XLEN and NREG, two read ports with bypass, one write port, asynchronous clear.

Test Plan:
- Write-back bypass: wb_en = 1, wb_rd = 5, wb_value = 0x1234; same cycle, accept ADD x1,x5,x0 -> next cycle op1 = 0x1234. A write with wb_rd = 0 leaves x0 reading 0.
- Load-use hazard: LD x3,0(x2) then ADD x4,x3,x1 -> one cycle with out_valid = 0 and stall_raise = 1, in_ready low for that cycle, then ADD issues. LD x3 then ADDI x4,x1,1 -> no bubble.
- Immediates: BEQ encoding with offset −8 -> imm = 0xFFFF_FFFF_FFFF_FFF8. LUI x1,0x80000 with XLEN = 64 -> op2 = 0xFFFF_FFFF_8000_0000.
- Backpressure: ex_ready low for 3 cycles with out_valid high -> outputs stable and in_ready = 0. Release -> the next instruction appears one cycle later.
- Flush: flush high while holding a valid instruction and in_valid high -> out_valid = 0 next cycle and the input is dropped. Asserting reset mid-stream -> all outputs and registers read 0 immediately.
- Illegal cases: ADDW with XLEN = 32 -> illegal = 1. ADD x17,x1,x2 with NREG = 16 -> illegal = 1, write_back = 0.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg - shared definitions for the RV instruction-decode stage.
//   * base opcode constants (RV32I / RV64I)
//   * canonical NOP encoding
//   * immediate-format, operand-select and store-data-select enums
//   * packed class-flag bundle carried from decode to execute
//   * imm_gen(): builds any immediate format, sign-extended to 64 bits
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef enum logic [1:0] {
        OP1_ZERO,
        OP1_RS1,
        OP1_PC
    } op1_sel_e;

    typedef enum logic [1:0] {
        OP2_ZERO,
        OP2_RS2,
        OP2_IMM,
        OP2_FOUR
    } op2_sel_e;

    typedef enum logic [1:0] {
        SD_ZERO,
        SD_RS1,
        SD_RS2
    } sd_sel_e;

    typedef struct packed {
        logic write_back;
        logic mem_acc;
        logic load_flag;
        logic store_flag;
        logic branch_flag;
        logic jump_flag;
        logic imm_flag;
        logic word_flag;
        logic illegal;
    } dec_flags_t;

    // Every format is sign-extended from inst[31]; callers truncate to XLEN,
    // which still yields a correct sign extension for XLEN = 32.
    function automatic logic [63:0] imm_gen(input logic [31:0] inst, input imm_fmt_e fmt);
        logic [63:0] imm;
        case (fmt)
            IMM_I:   imm = {{52{inst[31]}}, inst[31:20]};
            IMM_S:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
            IMM_J:   imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/rv_decode_if.sv
// rv_decode_if - all non-clock signals of the decode stage.
//   fetch side   : in_valid, in_ready, inst, pc, flush
//   write-back   : wb_en, wb_rd, wb_value
//   execute side : ex_ready, out_valid and the decoded bundle
// slave  = the decode stage's view, master = the surrounding pipeline's view.
interface rv_decode_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            flush;

    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_value;

    logic            ex_ready;
    logic            out_valid;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] store_data;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_out;
    logic            write_back;
    logic            mem_acc;
    logic            load_flag;
    logic            store_flag;
    logic            branch_flag;
    logic            jump_flag;
    logic            imm_flag;
    logic            word_flag;
    logic            illegal;
    logic            stall_raise;

    modport slave (
        input  in_valid, inst, pc, flush, wb_en, wb_rd, wb_value, ex_ready,
        output in_ready, out_valid, rd, rs1, rs2, funct3, funct7,
               op1, op2, store_data, imm, pc_out,
               write_back, mem_acc, load_flag, store_flag, branch_flag,
               jump_flag, imm_flag, word_flag, illegal, stall_raise
    );

    modport master (
        output in_valid, inst, pc, flush, wb_en, wb_rd, wb_value, ex_ready,
        input  in_ready, out_valid, rd, rs1, rs2, funct3, funct7,
               op1, op2, store_data, imm, pc_out,
               write_back, mem_acc, load_flag, store_flag, branch_flag,
               jump_flag, imm_flag, word_flag, illegal, stall_raise
    );

endinterface

// File: rtl/rv_regfile.sv
// rv_regfile - NREG x XLEN integer register file.
//   CLK, reset (async, active-low: clears every register)
//   wb_en / wb_rd / wb_value : write port, x0 is never written
//   raddr1/rdata1, raddr2/rdata2 : combinational read ports; a read of the
//   register being written this cycle returns wb_value (bypass).
// Indices >= NREG read as zero; the decoder flags them as illegal.
module rv_regfile #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_value,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);
    import rv_decode_pkg::*;

    localparam int         IDXW   = $clog2(NREG);
    localparam logic [5:0] NREG_W = 6'(NREG);

    logic [XLEN-1:0] regs_reg [NREG];
    logic [NREG-1:0] wr_sel;
    logic [4:0]      raddr [2];
    logic [XLEN-1:0] rdata [2];

    // One-hot write select; entry 0 is hard-wired off so x0 stays zero.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_x0
                assign wr_sel[gi] = 1'b0;
            end else begin : g_xn
                assign wr_sel[gi] = wb_en && (wb_rd == 5'(gi));
            end
        end
    endgenerate

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= wb_value;
                end
            end
        end
    end

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (raddr[p] == 5'd0 || {1'b0, raddr[p]} >= NREG_W) begin
                rdata[p] = '0;
            end else if (wb_en && wb_rd == raddr[p]) begin
                rdata[p] = wb_value;
            end else begin
                rdata[p] = regs_reg[raddr[p][IDXW-1:0]];
            end
        end
    end

    assign rdata1 = rdata[0];
    assign rdata2 = rdata[1];

endmodule

// File: rtl/rv_decode_stage.sv
// rv_decode_stage - ID stage between fetch and execute.
//   CLK    : clock, all state on posedge
//   reset  : asynchronous, active-low
//   bus    : rv_decode_if.slave - fetch handshake (in_valid/in_ready, inst,
//            pc, flush), write-back port (wb_en/wb_rd/wb_value) and the
//            registered execute bundle (out_valid/ex_ready, indices,
//            operands, immediate, class flags, stall_raise).
// Decodes RV32I/RV64I base opcodes, reads the register file with
// write-back bypass and inserts a one-cycle bubble on a load-use hazard
// against the instruction currently held in the output register.
module rv_decode_stage #(
    parameter int XLEN = 64,
    parameter int NREG = 32
) (
    input logic CLK,
    input logic reset,
    rv_decode_if.slave bus
);
    import rv_decode_pkg::*;

    localparam logic [5:0] NREG_W = 6'(NREG);

    // ---------------- held output bundle ----------------
    logic            out_valid_reg;
    logic            stall_raise_reg;
    logic [4:0]      rd_reg;
    logic [4:0]      rs1_reg;
    logic [4:0]      rs2_reg;
    logic [2:0]      funct3_reg;
    logic [6:0]      funct7_reg;
    logic [XLEN-1:0] op1_reg;
    logic [XLEN-1:0] op2_reg;
    logic [XLEN-1:0] store_data_reg;
    logic [XLEN-1:0] imm_reg;
    logic [XLEN-1:0] pc_out_reg;
    dec_flags_t      flags_reg;

    // ---------------- decode of the incoming word ----------------
    logic [31:0]     inst_dec;
    logic [6:0]      opcode;
    logic [4:0]      rd_f;
    logic [4:0]      rs1_f;
    logic [4:0]      rs2_f;
    dec_flags_t      flags_next;
    imm_fmt_e        imm_fmt;
    op1_sel_e        op1_sel;
    op2_sel_e        op2_sel;
    sd_sel_e         sd_sel;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            known;
    logic            word_op;
    logic            bad_reg;
    logic [63:0]     imm_full;
    logic [XLEN-1:0] imm_next;
    logic [XLEN-1:0] op1_next;
    logic [XLEN-1:0] op2_next;
    logic [XLEN-1:0] store_data_next;
    logic [4:0]      rd_next;
    logic [4:0]      rs1_next;
    logic [4:0]      rs2_next;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    logic            advance;
    logic            hazard;

    // Idle input decodes as a NOP so that nothing downstream (hazard check,
    // register reads) reacts to a stale instruction word.
    assign inst_dec = bus.in_valid ? bus.inst : INST_NOP;
    assign opcode   = inst_dec[6:0];
    assign rd_f     = inst_dec[11:7];
    assign rs1_f    = inst_dec[19:15];
    assign rs2_f    = inst_dec[24:20];

    rv_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .CLK      (CLK),
        .reset    (reset),
        .wb_en    (bus.wb_en),
        .wb_rd    (bus.wb_rd),
        .wb_value (bus.wb_value),
        .raddr1   (rs1_f),
        .raddr2   (rs2_f),
        .rdata1   (rs1_val),
        .rdata2   (rs2_val)
    );

    // imm_flag marks "op2 comes from the immediate"; branch and jump
    // immediates are carried on imm only.
    always_comb begin
        flags_next = '0;
        imm_fmt    = IMM_NONE;
        op1_sel    = OP1_ZERO;
        op2_sel    = OP2_ZERO;
        sd_sel     = SD_ZERO;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        known      = 1'b1;
        word_op    = 1'b0;
        bad_reg    = 1'b0;

        case (opcode)
            OPC_OP, OPC_OP_32: begin
                flags_next.write_back = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_RS2;
                word_op  = (opcode == OPC_OP_32);
            end
            OPC_OP_IMM, OPC_OP_IMM_32: begin
                flags_next.write_back = 1'b1;
                flags_next.imm_flag   = 1'b1;
                uses_rs1 = 1'b1;
                imm_fmt  = IMM_I;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_IMM;
                word_op  = (opcode == OPC_OP_IMM_32);
            end
            OPC_LOAD: begin
                flags_next.write_back = 1'b1;
                flags_next.mem_acc    = 1'b1;
                flags_next.load_flag  = 1'b1;
                flags_next.imm_flag   = 1'b1;
                uses_rs1 = 1'b1;
                imm_fmt  = IMM_I;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_IMM;
            end
            OPC_STORE: begin
                flags_next.mem_acc    = 1'b1;
                flags_next.store_flag = 1'b1;
                flags_next.imm_flag   = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_fmt  = IMM_S;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_IMM;
                sd_sel   = SD_RS2;
            end
            OPC_BRANCH: begin
                flags_next.branch_flag = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_fmt  = IMM_B;
                op1_sel  = OP1_RS1;
                op2_sel  = OP2_RS2;
            end
            OPC_LUI: begin
                flags_next.write_back = 1'b1;
                flags_next.imm_flag   = 1'b1;
                imm_fmt  = IMM_U;
                op1_sel  = OP1_ZERO;
                op2_sel  = OP2_IMM;
            end
            OPC_AUIPC: begin
                flags_next.write_back = 1'b1;
                flags_next.imm_flag   = 1'b1;
                imm_fmt  = IMM_U;
                op1_sel  = OP1_PC;
                op2_sel  = OP2_IMM;
            end
            OPC_JAL: begin
                flags_next.write_back = 1'b1;
                flags_next.jump_flag  = 1'b1;
                imm_fmt  = IMM_J;
                op1_sel  = OP1_PC;
                op2_sel  = OP2_FOUR;
            end
            OPC_JALR: begin
                // Link value is pc+4; the jump base (rs1) rides on store_data.
                flags_next.write_back = 1'b1;
                flags_next.jump_flag  = 1'b1;
                uses_rs1 = 1'b1;
                imm_fmt  = IMM_I;
                op1_sel  = OP1_PC;
                op2_sel  = OP2_FOUR;
                sd_sel   = SD_RS1;
            end
            default: begin
                known = 1'b0;
            end
        endcase

        if (word_op) begin
            if (XLEN == 64) begin
                flags_next.word_flag = 1'b1;
            end else begin
                known = 1'b0;
            end
        end

        bad_reg = (flags_next.write_back && ({1'b0, rd_f}  >= NREG_W)) ||
                  (uses_rs1              && ({1'b0, rs1_f} >= NREG_W)) ||
                  (uses_rs2              && ({1'b0, rs2_f} >= NREG_W));

        // An illegal word still issues, but must not write a register or
        // touch memory; clearing load/store also keeps it out of the
        // load-use hazard check.
        if (!known || bad_reg) begin
            flags_next.illegal    = 1'b1;
            flags_next.write_back = 1'b0;
            flags_next.mem_acc    = 1'b0;
            flags_next.load_flag  = 1'b0;
            flags_next.store_flag = 1'b0;
        end
    end

    assign imm_full = imm_gen(inst_dec, imm_fmt);
    assign imm_next = imm_full[XLEN-1:0];

    // Unused index fields are reported as x0 so downstream forwarding never
    // matches on immediate bits.
    assign rd_next  = flags_next.write_back ? rd_f  : 5'd0;
    assign rs1_next = uses_rs1              ? rs1_f : 5'd0;
    assign rs2_next = uses_rs2              ? rs2_f : 5'd0;

    always_comb begin
        case (op1_sel)
            OP1_RS1: op1_next = rs1_val;
            OP1_PC:  op1_next = bus.pc;
            default: op1_next = '0;
        endcase

        case (op2_sel)
            OP2_RS2:  op2_next = rs2_val;
            OP2_IMM:  op2_next = imm_next;
            OP2_FOUR: op2_next = XLEN'(4);
            default:  op2_next = '0;
        endcase

        case (sd_sel)
            SD_RS1:  store_data_next = rs1_val;
            SD_RS2:  store_data_next = rs2_val;
            default: store_data_next = '0;
        endcase
    end

    // ---------------- handshake ----------------
    assign advance = !out_valid_reg || bus.ex_ready;

    assign hazard = out_valid_reg && flags_reg.load_flag && (rd_reg != 5'd0) &&
                    ((uses_rs1 && rs1_f == rd_reg) || (uses_rs2 && rs2_f == rd_reg));

    // During flush the incoming word is swallowed, so fetch may always drop it.
    assign bus.in_ready = bus.flush || (advance && !hazard);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            out_valid_reg   <= 1'b0;
            stall_raise_reg <= 1'b0;
            rd_reg          <= '0;
            rs1_reg         <= '0;
            rs2_reg         <= '0;
            funct3_reg      <= '0;
            funct7_reg      <= '0;
            op1_reg         <= '0;
            op2_reg         <= '0;
            store_data_reg  <= '0;
            imm_reg         <= '0;
            pc_out_reg      <= '0;
            flags_reg       <= '0;
        end else if (bus.flush) begin
            out_valid_reg   <= 1'b0;
            stall_raise_reg <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                // Bubble: the held load leaves, the dependent word waits one
                // cycle and is then accepted with out_valid low (no hazard).
                out_valid_reg   <= 1'b0;
                stall_raise_reg <= 1'b1;
            end else if (bus.in_valid) begin
                out_valid_reg   <= 1'b1;
                stall_raise_reg <= 1'b0;
                rd_reg          <= rd_next;
                rs1_reg         <= rs1_next;
                rs2_reg         <= rs2_next;
                funct3_reg      <= inst_dec[14:12];
                funct7_reg      <= inst_dec[31:25];
                op1_reg         <= op1_next;
                op2_reg         <= op2_next;
                store_data_reg  <= store_data_next;
                imm_reg         <= imm_next;
                pc_out_reg      <= bus.pc;
                flags_reg       <= flags_next;
            end else begin
                out_valid_reg   <= 1'b0;
                stall_raise_reg <= 1'b0;
            end
        end else begin
            stall_raise_reg <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.stall_raise = stall_raise_reg;
    assign bus.rd          = rd_reg;
    assign bus.rs1         = rs1_reg;
    assign bus.rs2         = rs2_reg;
    assign bus.funct3      = funct3_reg;
    assign bus.funct7      = funct7_reg;
    assign bus.op1         = op1_reg;
    assign bus.op2         = op2_reg;
    assign bus.store_data  = store_data_reg;
    assign bus.imm         = imm_reg;
    assign bus.pc_out      = pc_out_reg;
    assign bus.write_back  = flags_reg.write_back;
    assign bus.mem_acc     = flags_reg.mem_acc;
    assign bus.load_flag   = flags_reg.load_flag;
    assign bus.store_flag  = flags_reg.store_flag;
    assign bus.branch_flag = flags_reg.branch_flag;
    assign bus.jump_flag   = flags_reg.jump_flag;
    assign bus.imm_flag    = flags_reg.imm_flag;
    assign bus.word_flag   = flags_reg.word_flag;
    assign bus.illegal     = flags_reg.illegal;

endmodule
